matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
Sequencer for the 2x2 signed matrix multiplier. It accepts one packed A word and one packed B word through a valid/ready handshake. It then time-shares a single internal multiply-accumulate unit over 8 steps to form C = A x B, and streams the four C elements out one at a time with a valid/ready handshake. It sits between the tile's dedicated input pins (ui_in for A, uio_in for B) and the output pins, and is gated by the tile enable.

Parameters:
ELEM_W, 2, width of each signed two's-complement matrix element (range -2..1 at the default).
OUT_W, 8, width of out_data; each C element is sign-extended to this width.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
ena  input  1  tile enable; when low, all state freezes
in_valid  input  1  A/B operand words valid
in_ready  output  1  controller can accept operands
a_word  input  4*ELEM_W  packed A: [7:6]=a00, [5:4]=a01, [3:2]=a10, [1:0]=a11 (at default)
b_word  input  4*ELEM_W  packed B, same packing as A
out_valid  output  1  out_data/out_idx hold a C element
out_ready  input  1  consumer accepts the C element
out_data  output  OUT_W  C element, sign-extended
out_idx  output  2  element index: 0=c00, 1=c01, 2=c10, 3=c11
busy  output  1  high in COMPUTE or OUTPUT
done  output  1  one-cycle pulse after c11 is accepted

Behaviour:
- Reset (rst=1 at an edge, regardless of state or ena):
  - state goes to IDLE; A/B/C registers, accumulator and counters clear to 0.
  - Next cycle: in_ready=1 (if ena=1), out_valid=0, out_data=0, out_idx=0, busy=0, done=0.
- States: IDLE, COMPUTE, OUTPUT.
- IDLE:
  - in_ready = ena.
  - When in_valid && in_ready: latch a_word and b_word, clear step to 0, go to COMPUTE.
  - Operands are sampled only at the accepting edge.
- COMPUTE:
  - in_ready=0. step counter runs 0..7. Element e = step[2:1] (row i=e[1], col j=e[0]); term k = step[0].
  - Each enabled cycle: prod = A[i][k] * B[k][j], full signed 2*ELEM_W product.
  - k=0: acc <= prod. k=1: C[e] <= acc + prod, and acc is not carried forward.
  - Accumulator and C width is 2*ELEM_W+1 signed (5 bits at default), so overflow is impossible.
  - After step 7: go to OUTPUT with idx=0.
- OUTPUT:
  - out_valid=1, out_data=sext(C[idx]), out_idx=idx.
  - A transfer occurs on an edge with out_valid && out_ready && ena; idx then increments.
  - Transfer at idx=3: go to IDLE and pulse done=1 for exactly one cycle (the cycle after that edge).
  - Without a transfer, out_data and out_idx are held stable.
- Latency with ena held high:
  - Operand accept at edge 0; COMPUTE occupies edges 1..8.
  - out_valid is first high after edge 8.
  - Minimum operand-to-done is 12 edges with out_ready held high.
- ena=0:
  - No state, counter, accumulator or register changes.
  - in_ready=0; no transfer completes even if out_ready=1.
  - out_valid and out_data stay at their current values, never dropping mid-handshake.
- No new operands are accepted until the FSM returns to IDLE. in_valid is ignored outside IDLE.
- done, busy, in_ready and out_valid are decoded from registered state and are glitch-free.
- out_data is driven 0 in IDLE and COMPUTE.

Test Plan:
- Reset, then A=8'b01010101, B=8'b01010101 (all 1), out_ready=1 -> out_valid rises after edge 8; outputs 8'h02 x4 with idx 0..3; done pulses once; in_ready returns to 1.
- A=B=8'b10101010 (all -2) -> all four outputs 8'h08, the maximum positive value, with no overflow.
- A=identity 8'b01000001, B=8'b01111000 (1,-1,-2,0) -> outputs 8'h01, 8'hFF, 8'hFE, 8'h00 in idx order.
- Same vectors with out_ready low for 3 cycles while idx=1 -> out_data=8'hFF and out_idx=1 held stable; no skipped or duplicated element; done delayed 3 cycles.
- ena low for 2 cycles at step 3 of COMPUTE -> first out_valid delayed by exactly 2 cycles; results unchanged. Also check in_ready=0 during any cycle with ena=0 in IDLE.
- rst pulsed at step 5 of COMPUTE, then new A=8'b01000001, B=8'b00010100 -> state returns to IDLE next cycle with busy=0 and out_valid=0; fresh results are 8'h00, 8'h01, 8'h01, 8'h00 with no stale data.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
//
// Sequencer for a 2x2 signed matrix multiplier. One A word and one B word are
// taken through a valid/ready handshake, a single multiply-accumulate datapath
// is time-shared over eight steps to form C = A x B, and the four C elements
// are then streamed out one per handshake in row-major order.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset (overrides ena)
//   ena        tile enable; when low every register holds its value
//   in_valid   A/B operand words are valid
//   in_ready   controller can accept operands (IDLE and enabled)
//   a_word     packed A, a00 in the most significant element slot
//   b_word     packed B, same packing as A
//   out_valid  out_data/out_idx carry a C element
//   out_ready  consumer accepts the current C element
//   out_data   C element, sign-extended to OUT_W (0 outside OUTPUT)
//   out_idx    element index: 0=c00, 1=c01, 2=c10, 3=c11
//   busy       high while computing or streaming results
//   done       one-cycle pulse after c11 has been accepted
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int ELEM_W = 2,
    parameter int OUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*ELEM_W-1:0]   a_word,
    input  logic [4*ELEM_W-1:0]   b_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [1:0]            out_idx,
    output logic                  busy,
    output logic                  done
);

    // Product of two ELEM_W signed values fits in 2*ELEM_W bits; the sum of
    // two such products needs one extra bit, so the accumulator never wraps.
    localparam int PW = 2 * ELEM_W;
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;

    logic [1:0]               r_state;
    logic [2:0]               r_step;
    logic [1:0]               r_idx;
    logic                     r_done;
    logic [4*ELEM_W-1:0]      r_a;
    logic [4*ELEM_W-1:0]      r_b;
    logic signed [CW-1:0]     r_acc;
    logic signed [CW-1:0]     r_c [4];

    // Unpacked operand elements, index n = row*2 + col.
    logic signed [ELEM_W-1:0] w_a_el [4];
    logic signed [ELEM_W-1:0] w_b_el [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            // Element 0 (x00) sits in the most significant slot.
            assign w_a_el[gi] = r_a[(3-gi)*ELEM_W +: ELEM_W];
            assign w_b_el[gi] = r_b[(3-gi)*ELEM_W +: ELEM_W];
        end
    endgenerate

    // Step decode: element e = step[2:1] (row e[1], col e[0]), term k = step[0].
    logic [1:0]               w_e;
    logic                     w_k;
    logic [1:0]               w_a_sel_idx;
    logic [1:0]               w_b_sel_idx;
    logic signed [ELEM_W-1:0] w_a_sel;
    logic signed [ELEM_W-1:0] w_b_sel;
    logic signed [PW-1:0]     w_a_ext;
    logic signed [PW-1:0]     w_b_ext;
    logic signed [PW-1:0]     w_prod;
    logic signed [CW-1:0]     w_prod_ext;
    logic signed [CW-1:0]     w_sum;

    assign w_e         = r_step[2:1];
    assign w_k         = r_step[0];
    assign w_a_sel_idx = {w_e[1], w_k};   // A[i][k]
    assign w_b_sel_idx = {w_k, w_e[0]};   // B[k][j]
    assign w_a_sel     = w_a_el[w_a_sel_idx];
    assign w_b_sel     = w_b_el[w_b_sel_idx];

    // Operands are widened to the product width first so the multiply is
    // evaluated at full precision without relying on context sizing.
    assign w_a_ext    = {{ELEM_W{w_a_sel[ELEM_W-1]}}, w_a_sel};
    assign w_b_ext    = {{ELEM_W{w_b_sel[ELEM_W-1]}}, w_b_sel};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {w_prod[PW-1], w_prod};
    assign w_sum      = r_acc + w_prod_ext;

    // Sequential state. With ena low nothing moves, including the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= 3'd0;
            r_idx   <= 2'd0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_c     <= '{default: '0};
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // in_ready is exactly "IDLE and ena", so in_valid alone
                    // completes the handshake here.
                    if (in_valid) begin
                        r_a     <= a_word;
                        r_b     <= b_word;
                        r_step  <= 3'd0;
                        r_idx   <= 2'd0;
                        r_acc   <= '0;
                        r_state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (!w_k) begin
                        r_acc <= w_prod_ext;
                    end else begin
                        // Second term closes the element; the accumulator is
                        // cleared so nothing leaks into the next element.
                        r_c[w_e] <= w_sum;
                        r_acc    <= '0;
                    end
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd7) begin
                        r_state <= S_OUTPUT;
                        r_idx   <= 2'd0;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode, all from registered state apart from the ena gate on
    // in_ready.
    logic signed [CW-1:0] w_c_sel;
    assign w_c_sel = r_c[r_idx];

    assign in_ready  = (r_state == S_IDLE) && ena;
    assign out_valid = (r_state == S_OUTPUT);
    assign busy      = (r_state == S_COMPUTE) || (r_state == S_OUTPUT);
    assign done      = r_done;
    assign out_idx   = r_idx;
    // OUT_W is expected to be wider than the C element width.
    assign out_data  = (r_state == S_OUTPUT) ?
                       {{(OUT_W-CW){w_c_sel[CW-1]}}, w_c_sel} : '0;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
module tb_matmul_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_word;
    logic [7:0] b_word;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_idx;
    logic       busy;
    logic       done;

    matmul_seq_ctrl #(.ELEM_W(2), .OUT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_word    (a_word),
        .b_word    (b_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Capture results of one operation (filled by collect, compared by tests).
    logic [7:0] cap_data [8];
    logic [1:0] cap_idx  [8];
    int         ncap;
    logic [7:0] hold_data [8];
    logic [1:0] hold_idx  [8];
    int         nhold;
    int         t_valid;
    int         t_done;
    int         done_pulses;
    bit         saw_ready_busy;

    // Reference model: plain 2x2 matrix arithmetic on signed 2-bit elements.
    function automatic int el(input logic [7:0] w, input int n);
        int v;
        v = int'(w >> (2 * (3 - n))) & 3;
        if (v >= 2) v -= 4;
        return v;
    endfunction

    function automatic logic [7:0] ref_c(input logic [7:0] a, input logic [7:0] b, input int e);
        int i, j, s;
        i = e / 2;
        j = e % 2;
        s = el(a, 2*i) * el(b, j) + el(a, 2*i + 1) * el(b, 2 + j);
        return 8'(s);
    endfunction

    // Present operands for one accepting edge (caller is just after an edge).
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        a_word   = a;
        b_word   = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Run the consumer side after an accept; edges counted from the accept.
    // hold_i/hold_n: drop out_ready for hold_n cycles while idx==hold_i.
    // ena_at/ena_n: ena low for edges ena_at+1 .. ena_at+ena_n.
    task automatic collect(input int hold_i, input int hold_n, input int ena_at, input int ena_n);
        ncap = 0; nhold = 0; t_valid = -1; t_done = -1;
        done_pulses = 0; saw_ready_busy = 0;
        out_ready = 1'b1;
        for (int e = 1; e <= 60 && t_done < 0; e++) begin
            ena = !((e > ena_at) && (e <= ena_at + ena_n));
            @(posedge clk); #1;
            if (done) begin
                done_pulses++;
                if (t_done < 0) t_done = e;
            end
            if (in_ready && busy) saw_ready_busy = 1;
            if (out_valid) begin
                if (t_valid < 0) t_valid = e;
                if (int'(out_idx) == hold_i && nhold < hold_n) begin
                    out_ready = 1'b0;
                    if (nhold < 8) begin
                        hold_data[nhold] = out_data;
                        hold_idx[nhold]  = out_idx;
                    end
                    nhold++;
                end else begin
                    out_ready = 1'b1;
                    if (ncap < 8) begin
                        cap_data[ncap] = out_data;
                        cap_idx[ncap]  = out_idx;
                    end
                    ncap++;
                end
            end
        end
        ena = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_word = 8'h00; b_word = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (out_idx !== 2'd0)   begin errors++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
        rst = 1'b0;
        ena = 1'b0; #1;
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL idle_ena_low_in_ready got %b want 0", in_ready); end
        ena = 1'b1; #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL idle_ena_high_in_ready got %b want 1", in_ready); end
        $display("reset: in_ready=%b busy=%b out_valid=%b", in_ready, busy, out_valid);
    endtask

    task automatic test_directed();
        logic [7:0] ta [3] = '{8'h55, 8'hAA, 8'h41};
        logic [7:0] tb [3] = '{8'h55, 8'hAA, 8'h78};
        logic [7:0] te [3][4] = '{'{8'h02, 8'h02, 8'h02, 8'h02},
                                  '{8'h08, 8'h08, 8'h08, 8'h08},
                                  '{8'h01, 8'hFF, 8'hFE, 8'h00}};
        for (int v = 0; v < 3; v++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %b want 1", v, in_ready); end
            send(ta[v], tb[v]);
            collect(-1, 0, -1, 0);
            checks++; if (t_valid != 8)     begin errors++; $display("FAIL dir%0d_first_valid got %0d want 8", v, t_valid); end
            checks++; if (t_done != 12)     begin errors++; $display("FAIL dir%0d_done_edge got %0d want 12", v, t_done); end
            checks++; if (done_pulses != 1) begin errors++; $display("FAIL dir%0d_done_pulses got %0d want 1", v, done_pulses); end
            checks++; if (ncap != 4)        begin errors++; $display("FAIL dir%0d_count got %0d want 4", v, ncap); end
            checks++; if (saw_ready_busy)   begin errors++; $display("FAIL dir%0d_in_ready_while_busy got 1 want 0", v); end
            for (int n = 0; n < 4 && n < ncap; n++) begin
                checks++; if (cap_data[n] !== te[v][n]) begin errors++; $display("FAIL dir%0d_data%0d got %h want %h", v, n, cap_data[n], te[v][n]); end
                checks++; if (cap_idx[n] !== 2'(n))     begin errors++; $display("FAIL dir%0d_idx%0d got %0d want %0d", v, n, cap_idx[n], n); end
            end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0)     begin errors++; $display("FAIL dir%0d_done_width got %b want 0", v, done); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_ready_return got %b want 1", v, in_ready); end
            $display("op a=%h b=%h c=%h %h %h %h done@%0d", ta[v], tb[v], cap_data[0], cap_data[1], cap_data[2], cap_data[3], t_done);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] te [4] = '{8'h01, 8'hFF, 8'hFE, 8'h00};
        send(8'h41, 8'h78);
        collect(1, 3, -1, 0);
        checks++; if (nhold != 3)   begin errors++; $display("FAIL bp_hold_count got %0d want 3", nhold); end
        for (int n = 0; n < 3 && n < nhold; n++) begin
            checks++; if (hold_data[n] !== 8'hFF) begin errors++; $display("FAIL bp_hold_data%0d got %h want ff", n, hold_data[n]); end
            checks++; if (hold_idx[n] !== 2'd1)   begin errors++; $display("FAIL bp_hold_idx%0d got %0d want 1", n, hold_idx[n]); end
        end
        checks++; if (t_done != 15) begin errors++; $display("FAIL bp_done_edge got %0d want 15", t_done); end
        checks++; if (ncap != 4)    begin errors++; $display("FAIL bp_count got %0d want 4", ncap); end
        for (int n = 0; n < 4 && n < ncap; n++) begin
            checks++; if (cap_data[n] !== te[n] || cap_idx[n] !== 2'(n)) begin
                errors++; $display("FAIL bp_elem%0d got %h/%0d want %h/%0d", n, cap_data[n], cap_idx[n], te[n], n);
            end
        end
        $display("op a=41 b=78 backpressure idx1x3 done@%0d", t_done);
    endtask

    task automatic test_ena_stall();
        logic [7:0] te [4] = '{8'h01, 8'hFF, 8'hFE, 8'h00};
        send(8'h41, 8'h78);
        collect(-1, 0, 3, 2);
        checks++; if (t_valid != 10) begin errors++; $display("FAIL ena_first_valid got %0d want 10", t_valid); end
        checks++; if (t_done != 14)  begin errors++; $display("FAIL ena_done_edge got %0d want 14", t_done); end
        checks++; if (ncap != 4)     begin errors++; $display("FAIL ena_count got %0d want 4", ncap); end
        for (int n = 0; n < 4 && n < ncap; n++) begin
            checks++; if (cap_data[n] !== te[n] || cap_idx[n] !== 2'(n)) begin
                errors++; $display("FAIL ena_elem%0d got %h/%0d want %h/%0d", n, cap_data[n], cap_idx[n], te[n], n);
            end
        end
        // Back in IDLE: ena low must withhold in_ready and block acceptance.
        ena = 1'b0; in_valid = 1'b1; a_word = 8'h55; b_word = 8'h55; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ena_idle_in_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL ena_idle_no_accept busy got %b want 0", busy); end
        in_valid = 1'b0; ena = 1'b1;
        $display("op a=41 b=78 ena-stall@3x2 valid@%0d done@%0d", t_valid, t_done);
    endtask

    task automatic test_reset_mid();
        logic [7:0] te [4] = '{8'h00, 8'h01, 8'h01, 8'h00};
        send(8'h41, 8'h78);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        send(8'h41, 8'h14);
        collect(-1, 0, -1, 0);
        checks++; if (t_done != 12) begin errors++; $display("FAIL rstmid_done_edge got %0d want 12", t_done); end
        checks++; if (ncap != 4)    begin errors++; $display("FAIL rstmid_count got %0d want 4", ncap); end
        for (int n = 0; n < 4 && n < ncap; n++) begin
            checks++; if (cap_data[n] !== te[n] || cap_idx[n] !== 2'(n)) begin
                errors++; $display("FAIL rstmid_elem%0d got %h/%0d want %h/%0d", n, cap_data[n], cap_idx[n], te[n], n);
            end
        end
        $display("op a=41 b=14 after mid-compute reset c=%h %h %h %h", cap_data[0], cap_data[1], cap_data[2], cap_data[3]);
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            logic [7:0] a, b;
            int hi, hn;
            a  = 8'($urandom);
            b  = 8'($urandom);
            hi = int'($urandom_range(0, 3));
            hn = int'($urandom_range(0, 3));
            send(a, b);
            collect(hi, hn, -1, 0);
            checks++; if (t_done != 12 + hn) begin errors++; $display("FAIL rnd%0d_done_edge got %0d want %0d", r, t_done, 12 + hn); end
            checks++; if (ncap != 4)         begin errors++; $display("FAIL rnd%0d_count got %0d want 4", r, ncap); end
            for (int n = 0; n < 4 && n < ncap; n++) begin
                checks++; if (cap_data[n] !== ref_c(a, b, n) || cap_idx[n] !== 2'(n)) begin
                    errors++; $display("FAIL rnd%0d_elem%0d a=%h b=%h got %h/%0d want %h/%0d", r, n, a, b, cap_data[n], cap_idx[n], ref_c(a, b, n), n);
                end
            end
            $display("op a=%h b=%h c=%h %h %h %h hold=%0dx%0d done@%0d", a, b, cap_data[0], cap_data[1], cap_data[2], cap_data[3], hi, hn, t_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a [2];
        logic [7:0] b [2];
        for (int r = 0; r < 2; r++) begin
            a[r] = 8'($urandom);
            b[r] = 8'($urandom);
        end
        for (int r = 0; r < 2; r++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_in_ready got %b want 1", r, in_ready); end
            send(a[r], b[r]);
            // Junk operands held valid while busy must be ignored.
            in_valid = 1'b1; a_word = ~a[r]; b_word = ~b[r];
            collect(-1, 0, -1, 0);
            checks++; if (t_done != 12)    begin errors++; $display("FAIL b2b%0d_done_edge got %0d want 12", r, t_done); end
            checks++; if (saw_ready_busy)  begin errors++; $display("FAIL b2b%0d_in_ready_while_busy got 1 want 0", r); end
            checks++; if (ncap != 4)       begin errors++; $display("FAIL b2b%0d_count got %0d want 4", r, ncap); end
            for (int n = 0; n < 4 && n < ncap; n++) begin
                checks++; if (cap_data[n] !== ref_c(a[r], b[r], n)) begin
                    errors++; $display("FAIL b2b%0d_elem%0d got %h want %h", r, n, cap_data[n], ref_c(a[r], b[r], n));
                end
            end
            $display("op a=%h b=%h c=%h %h %h %h back-to-back done@%0d", a[r], b[r], cap_data[0], cap_data[1], cap_data[2], cap_data[3], t_done);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_ena_stall();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
